// File: rtl/text_scroll_buffer.sv
// text_scroll_buffer: collects a typed message into a character buffer and
// presents a registered 16-character window to an alphanumeric display.
// Messages of up to 16 characters are shown statically; longer messages
// scroll left one character every SCROLL_TICKS cycles. Four blank columns
// separate the end of the message from its wrapped start.
//
// Input protocol: ascii_in_ready, txt_start and done are single-cycle
// strobes with no back-pressure. A strobe is acted on in the cycle it is
// high, and only in a state that accepts it. txt_start outranks everything
// except reset.
module text_scroll_buffer #(
    parameter int SCROLL_TICKS = 27000000,
    parameter int MAX_CHARS    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   ascii_in,
    input  logic         ascii_in_ready,
    input  logic         txt_start,
    input  logic         done,
    output logic [127:0] string_data,
    output logic [6:0]   msg_len,
    output logic         scrolling,
    output logic         overflow,
    output logic [1:0]   state_o      // debug view of the FSM state
);

    localparam int AW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int TW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCROLL_TICKS - 1);
    localparam logic [6:0]    MAX_LEN    = 7'(MAX_CHARS);
    localparam logic [7:0]    BACKSPACE  = 8'h08;
    localparam logic [7:0]    SPACE      = 8'h20;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, SCROLL} state_t;

    state_t        state_q, state_d;
    logic [6:0]    len_q, len_d;
    logic [6:0]    offset_q, offset_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          overflow_q, overflow_d;
    logic [127:0]  string_data_q, win_d;
    logic [7:0]    buf_q [MAX_CHARS];
    logic          wr_en;

    // Next-state logic: message start, character entry, scroll stepping.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        offset_d   = offset_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (txt_start) begin
            state_d    = LOAD;
            len_d      = '0;
            offset_d   = '0;
            timer_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (ascii_in_ready) begin
                        if (ascii_in == BACKSPACE) begin
                            if (len_q != 7'd0) len_d = len_q - 7'd1;
                        end else if (len_q == MAX_LEN) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            len_d = len_q + 7'd1;
                        end
                    end
                    // A char arriving with done still counts toward the length.
                    if (done) begin
                        if (len_d <= 7'd16) begin
                            state_d = SHOW;
                        end else begin
                            state_d  = SCROLL;
                            offset_d = '0;
                            timer_d  = '0;
                        end
                    end
                end
                SCROLL: begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d  = '0;
                        // Period is msg_len + 4, so the last offset is msg_len + 3.
                        offset_d = (offset_q == len_q + 7'd3) ? 7'd0 : offset_q + 7'd1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Window assembly from the current registered state; registered below.
    always_comb begin
        logic [7:0] vidx;
        logic [7:0] period;
        win_d  = '0;
        period = {1'b0, len_q} + 8'd4;
        vidx   = '0;
        for (int i = 0; i < 16; i++) begin
            vidx = {1'b0, offset_q} + 8'(i);
            // offset < period and i < 16 < period, so one subtraction wraps.
            if (state_q == SCROLL && vidx >= period) vidx = vidx - period;
            if (vidx < {1'b0, len_q}) win_d[127-8*i -: 8] = buf_q[vidx[AW-1:0]];
            else                      win_d[127-8*i -: 8] = SPACE;
        end
    end

    // Control registers and the registered display window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            offset_q      <= '0;
            timer_q       <= '0;
            overflow_q    <= 1'b0;
            string_data_q <= {16{SPACE}};
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            offset_q      <= offset_d;
            timer_q       <= timer_d;
            overflow_q    <= overflow_d;
            string_data_q <= win_d;
        end
    end

    // Character storage; stale entries beyond msg_len are masked, never cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) buf_q[len_q[AW-1:0]] <= ascii_in;
    end

    assign string_data = string_data_q;
    assign msg_len     = len_q;
    assign scrolling   = (state_q == SCROLL);
    assign overflow    = overflow_q;
    assign state_o     = state_q;

endmodule
